// File: rtl/aes_inv_sub_bytes_sched_if.sv
// Request/response bundle between the round datapath, the key schedule and the
// shared inverse S-box scheduler.
interface aes_inv_sub_bytes_sched_if;
    logic         st_valid;
    logic         st_ready;
    logic [127:0] st_in;
    logic         st_out_valid;
    logic         st_out_ready;
    logic [127:0] st_out;

    logic         wd_valid;
    logic         wd_ready;
    logic [31:0]  wd_in;
    logic         wd_out_valid;
    logic [31:0]  wd_out;

    // Requesters (round datapath and key schedule).
    modport master (
        output st_valid, st_in, st_out_ready, wd_valid, wd_in,
        input  st_ready, st_out_valid, st_out, wd_ready, wd_out_valid, wd_out
    );

    // Scheduler side.
    modport slave (
        input  st_valid, st_in, st_out_ready, wd_valid, wd_in,
        output st_ready, st_out_valid, st_out, wd_ready, wd_out_valid, wd_out
    );
endinterface

// File: rtl/aes_inv_sub_bytes_sched.sv
// Time-shares one external 32-bit inverse S-box between a 128-bit InvSubBytes
// state request (one column per cycle) and a 32-bit key-schedule word request.
module aes_inv_sub_bytes_sched #(
    parameter bit WORD_EN    = 1'b1,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    aes_inv_sub_bytes_sched_if.slave         bus,
    output logic [31:0]                      sb_word,
    input  logic [31:0]                      sb_result,
    output logic                             busy
);

    typedef enum logic [1:0] {StIdle, StSub, StHold, StWord} state_e;

    state_e       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic         rr_q, rr_d;
    logic [127:0] buf_q, buf_d;
    logic [31:0]  wd_q, wd_d;
    logic [31:0]  wd_out_q, wd_out_d;
    logic         wd_out_valid_q, wd_out_valid_d;

    logic         idle;
    logic         word_wins;
    logic         contention;
    logic         st_ready;
    logic         wd_ready;
    logic         st_hs;
    logic         wd_hs;
    logic [6:0]   col_lsb;

    assign idle       = (state_q == StIdle);
    assign word_wins  = FIXED_PRIO ? 1'b1 : rr_q;
    assign contention = bus.st_valid & bus.wd_valid & WORD_EN;

    // Grants are mutually exclusive: under contention exactly one ready is low.
    assign st_ready = idle & ~(bus.wd_valid & WORD_EN & word_wins);
    assign wd_ready = idle & WORD_EN & ~(bus.st_valid & ~word_wins);
    assign st_hs    = bus.st_valid & st_ready;
    assign wd_hs    = bus.wd_valid & wd_ready;

    // Column 0 lives in the top 32 bits, so its LSB index is (3 - col) * 32.
    assign col_lsb = {~col_q, 5'd0};

    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        rr_d           = rr_q;
        buf_d          = buf_q;
        wd_d           = wd_q;
        wd_out_d       = wd_out_q;
        wd_out_valid_d = 1'b0;
        sb_word        = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (st_hs) begin
                    buf_d   = bus.st_in;
                    col_d   = 2'd0;
                    state_d = StSub;
                    if (contention) begin
                        rr_d = 1'b1;
                    end
                end else if (wd_hs) begin
                    wd_d    = bus.wd_in;
                    state_d = StWord;
                    if (contention) begin
                        rr_d = 1'b0;
                    end
                end
            end
            StSub: begin
                sb_word                 = buf_q[col_lsb +: 32];
                buf_d[col_lsb +: 32]    = sb_result;
                col_d                   = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (bus.st_out_ready) begin
                    state_d = StIdle;
                end
            end
            StWord: begin
                sb_word        = wd_q;
                wd_out_d       = sb_result;
                wd_out_valid_d = 1'b1;
                state_d        = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            col_q          <= 2'd0;
            rr_q           <= 1'b0;
            buf_q          <= 128'd0;
            wd_q           <= 32'd0;
            wd_out_q       <= 32'd0;
            wd_out_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            rr_q           <= rr_d;
            buf_q          <= buf_d;
            wd_q           <= wd_d;
            wd_out_q       <= wd_out_d;
            wd_out_valid_q <= wd_out_valid_d;
        end
    end

    assign bus.st_ready     = st_ready;
    assign bus.wd_ready     = wd_ready;
    assign bus.st_out_valid = (state_q == StHold);
    assign bus.st_out       = buf_q;
    assign bus.wd_out_valid = wd_out_valid_q & WORD_EN;
    assign bus.wd_out       = wd_out_q;
    assign busy             = ~idle;

endmodule
